// File: rtl/sys_tick_gen_pkg.sv
// +----------------------------------------------------------------------------+
// | sys_tick_gen_pkg : shared widths and defaults for the tick timebase        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sys_tick_gen_pkg;

  localparam int c_div_w_def    = 16;
  localparam int c_div_init_def = 4;

  // Channel-select width; a single channel still gets a 1-bit selector.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_tick_gen_chan.sv
// +----------------------------------------------------------------------------+
// | sys_tick_gen_chan : one programmable tick/phase channel                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sys_tick_gen_chan #(
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_freeze,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wval,
  input  logic             i_sync,
  output logic             o_tick,
  output logic             o_phase
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             act_q, act_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             w_wrap;
  logic             w_load;
  logic [DIV_W:0]   w_half;

  // An idle channel reloads every cycle, so a restart always begins a fresh
  // period with the latest pending divider.
  always_comb begin
    pend_d  = i_wr ? i_wval : pend_q;
    w_wrap  = act_q && (cnt_q == (div_q - DIV_W'(1)));
    w_load  = i_sync || w_wrap || !act_q;
    div_d   = w_load ? pend_d : div_q;
    act_d   = !i_freeze && i_en && (div_d != '0);
    cnt_d   = '0;
    if (act_d && !w_load) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    w_half  = ({1'b0, div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    tick_d  = act_d && (cnt_d == '0);
    phase_d = act_d && ({1'b0, cnt_d} < w_half);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_INIT);
      pend_q  <= DIV_W'(DIV_INIT);
      act_q   <= 1'b0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign o_tick  = tick_q;
  assign o_phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/sys_tick_gen.sv
// +----------------------------------------------------------------------------+
// | sys_tick_gen : reset stretcher plus NUM_CH programmable tick channels      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sys_tick_gen
  import sys_tick_gen_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int DIV_W    = c_div_w_def,
  parameter  int DIV_INIT = c_div_init_def,
  parameter  int RST_HOLD = 5,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              nios_clk,
  input  logic              reset,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_sel,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_req,
  output logic              rst_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] phase
);

  localparam int c_hold_w = $clog2(RST_HOLD + 1);

  logic [c_hold_w-1:0] hold_q, hold_d;
  logic                rst_out_q, rst_out_d;

  // Saturating hold counter; rst_out drops on the edge that reaches RST_HOLD.
  always_comb begin
    hold_d = hold_q;
    if (hold_q != c_hold_w'(RST_HOLD)) begin
      hold_d = hold_q + c_hold_w'(1);
    end
    rst_out_d = (hold_d != c_hold_w'(RST_HOLD));
  end

  always_ff @(posedge nios_clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      rst_out_q <= 1'b1;
    end else begin
      hold_q    <= hold_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out = rst_out_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_wr;

      // Out-of-range selects match no channel and are dropped.
      assign w_wr = div_wr && (div_sel == CH_W'(i));

      sys_tick_gen_chan #(
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
      ) u_chan (
        .clk      (nios_clk),
        .rst      (reset),
        .i_freeze (rst_out_q),
        .i_en     (ch_en[i]),
        .i_wr     (w_wr),
        .i_wval   (div_val),
        .i_sync   (sync_req),
        .o_tick   (tick[i]),
        .o_phase  (phase[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sys_tick_gen.sv
// +----------------------------------------------------------------------------+
// | tb_sys_tick_gen : directed self-checking bench for sys_tick_gen            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_sys_tick_gen;

  logic        nios_clk = 1'b0;
  logic        reset    = 1'b0;
  logic        div_wr   = 1'b0;
  logic [0:0]  div_sel  = 1'b0;
  logic [15:0] div_val  = 16'd0;
  logic [1:0]  ch_en    = 2'b11;
  logic        sync_req = 1'b0;
  logic        rst_out;
  logic [1:0]  tick;
  logic [1:0]  phase;

  // Three-channel instance: a 2-bit select can address a channel that does not exist.
  logic        div_wr3  = 1'b1;
  logic [1:0]  div_sel3 = 2'd3;
  logic [15:0] div_val3 = 16'd9;
  logic [2:0]  ch_en3   = 3'b111;
  logic        sync3    = 1'b0;
  logic        rst_out3;
  logic [2:0]  tick3;
  logic [2:0]  phase3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 nios_clk = ~nios_clk;

  sys_tick_gen #(
    .NUM_CH(2), .DIV_W(16), .DIV_INIT(4), .RST_HOLD(5)
  ) dut (
    .nios_clk (nios_clk),
    .reset    (reset),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .ch_en    (ch_en),
    .sync_req (sync_req),
    .rst_out  (rst_out),
    .tick     (tick),
    .phase    (phase)
  );

  sys_tick_gen #(
    .NUM_CH(3), .DIV_W(16), .DIV_INIT(4), .RST_HOLD(5)
  ) dut3 (
    .nios_clk (nios_clk),
    .reset    (reset),
    .div_wr   (div_wr3),
    .div_sel  (div_sel3),
    .div_val  (div_val3),
    .ch_en    (ch_en3),
    .sync_req (sync3),
    .rst_out  (rst_out3),
    .tick     (tick3),
    .phase    (phase3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge nios_clk);
    #1;
  endtask

  // Period p == 0 means the channel is expected to be idle.
  function automatic logic e_tick(input int c, input int p);
    if (p == 0) return 1'b0;
    return (c % p) == 0;
  endfunction

  function automatic logic e_phase(input int c, input int p);
    if (p == 0) return 1'b0;
    return (c % p) < ((p + 1) / 2);
  endfunction

  // Check n cycles starting at counts s0/s1 with periods p0/p1, advancing one edge after each.
  task automatic run_chk(input string tag, input int n, input int s0, input int p0,
                         input int s1, input int p1);
    for (int k = 0; k < n; k++) begin
      logic [1:0] et;
      logic [1:0] ep;
      et = {e_tick(s1 + k, p1), e_tick(s0 + k, p0)};
      ep = {e_phase(s1 + k, p1), e_phase(s0 + k, p0)};
      check($sformatf("%s.tick[%0d]", tag, k), 32'(tick), 32'(et));
      check($sformatf("%s.phase[%0d]", tag, k), 32'(phase), 32'(ep));
      cyc();
    end
  endtask

  task automatic release_and_hold(input string tag);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("%s.rst_out[%0d]", tag, k), 32'(rst_out), 32'(k < 5));
    end
    check({tag, ".frozen_tick"}, 32'(tick), 32'd0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b1;
    cyc();
    cyc();
    check("rst.rst_out", 32'(rst_out), 32'd1);
    check("rst.tick", 32'(tick), 32'd0);
    check("rst.phase", 32'(phase), 32'd0);

    // Reset stretch and aligned default period of 4.
    release_and_hold("t1");
    run_chk("t1", 8, 0, 4, 0, 4);
    run_chk("t1b", 1, 0, 4, 0, 4);

    // ch1 <- 10 while cnt1 == 1: current period completes first.
    div_wr = 1'b1; div_sel = 1'b1; div_val = 16'd10;
    run_chk("t2w", 1, 1, 4, 1, 4);
    div_wr = 1'b0;
    run_chk("t2a", 2, 2, 4, 2, 4);
    run_chk("t2b", 21, 0, 4, 0, 10);

    // Two writes before wrap: last wins; then period 1.
    div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd3;
    run_chk("t3w1", 1, 1, 4, 1, 10);
    div_val = 16'd7;
    run_chk("t3w2", 1, 2, 4, 2, 10);
    div_wr = 1'b0;
    run_chk("t3a", 1, 3, 4, 3, 10);
    run_chk("t3b", 15, 0, 7, 4, 10);
    div_wr = 1'b1; div_val = 16'd1;
    run_chk("t3w3", 1, 1, 7, 9, 10);
    div_wr = 1'b0;
    run_chk("t3c", 5, 2, 7, 0, 10);
    run_chk("t3d", 6, 0, 1, 5, 10);

    // Misalign to 3 / 5, then realign with sync_req (sync coincides with a ch0 wrap).
    div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd3;
    run_chk("t4w0", 1, 0, 1, 1, 10);
    div_sel = 1'b1; div_val = 16'd5;
    run_chk("t4w1", 1, 0, 3, 2, 10);
    div_wr = 1'b0;
    run_chk("t4a", 7, 1, 3, 3, 10);
    run_chk("t4b", 3, 2, 3, 0, 5);
    sync_req = 1'b1;
    run_chk("t4s", 1, 2, 3, 3, 5);
    sync_req = 1'b0;
    run_chk("t4c", 6, 0, 3, 0, 5);
    // Sync also applies a pending divider immediately.
    div_wr = 1'b1; div_sel = 1'b1; div_val = 16'd6;
    run_chk("t4w2", 1, 0, 3, 1, 5);
    div_wr = 1'b0; sync_req = 1'b1;
    run_chk("t4s2", 1, 1, 3, 2, 5);
    sync_req = 1'b0;
    run_chk("t4d", 6, 0, 3, 0, 6);

    // ch_en[0] low, then high; then divider 0 stops at wrap; nonzero restarts next cycle.
    ch_en = 2'b10;
    run_chk("t5a", 1, 0, 3, 0, 6);
    run_chk("t5off", 6, 0, 0, 1, 6);
    ch_en = 2'b11;
    run_chk("t5b", 1, 0, 0, 1, 6);
    run_chk("t5on", 3, 0, 3, 2, 6);
    div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd0;
    run_chk("t5w0", 1, 0, 3, 5, 6);
    div_wr = 1'b0;
    run_chk("t5c", 2, 1, 3, 0, 6);
    run_chk("t5stop", 4, 0, 0, 2, 6);
    div_wr = 1'b1; div_val = 16'd2;
    run_chk("t5w2", 1, 0, 0, 0, 6);
    div_wr = 1'b0;
    run_chk("t5d", 4, 0, 2, 1, 6);

    // Asynchronous reset mid-period.
    run_chk("t6a", 2, 0, 2, 5, 6);
    reset = 1'b1;
    #1;
    check("t6.async_rst_out", 32'(rst_out), 32'd1);
    check("t6.async_tick", 32'(tick), 32'd0);
    check("t6.async_phase", 32'(phase), 32'd0);
    cyc();
    cyc();
    release_and_hold("t6");
    run_chk("t6b", 4, 0, 4, 0, 4);

    // The select-3 writes held on dut3 throughout must never have landed.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6.sel3_tick[%0d]", k), 32'(tick3), 32'(e_tick(k, 4) ? 3'b111 : 3'b000));
      check($sformatf("t6.sel3_phase[%0d]", k), 32'(phase3), 32'(e_phase(k, 4) ? 3'b111 : 3'b000));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
